quadra_obuf: RTL
================

# quadra_obuf

Output buffer placed directly downstream of the quadra pipeline top level. It captures every result the pipeline emits, writing `y` on each cycle that `y_dv` is high. The results are stored in a first-word-fall-through FIFO. A downstream consumer drains them through a valid/ready handshake. The quadra pipeline has no backpressure, so this block absorbs consumer stalls and flags any sample it has to drop.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `AFULL_LVL`, default 6: occupancy at or above which `afull` asserts; range 1 to `DEPTH`.

Ports:
- `clk`, input, `ck_t`: the single clock.
- `rst`, input, `rs_t`: reset. One clock; reset is asynchronous and active-high.
- `y`, input, `y_t`: result from the quadra pipeline.
- `y_dv`, input, `dv_t`: `y` is valid this cycle (push request).
- `m_data`, output, `y_t`: head-of-FIFO sample.
- `m_valid`, output, 1: `m_data` is valid.
- `m_ready`, input, 1: consumer accepts `m_data` when `m_valid` is also high.
- `count`, output, `$clog2(DEPTH)+1`: current occupancy.
- `afull`, output, 1: `count >= AFULL_LVL`.
- `ovf`, output, 1: sticky overflow flag.
- `ovf_clr`, input, 1: synchronous clear of `ovf`.

## Operation
- **Push:** `y_dv` high. Write `y` at `wr_ptr`, then advance `wr_ptr` modulo `DEPTH`.
- **Pop:** `m_valid && m_ready`. Advance `rd_ptr` modulo `DEPTH`.
- **Pointers:** `$clog2(DEPTH)+1` bits each. The extra MSB distinguishes full from empty.
  - Empty: the pointers are equal.
  - Full: the MSBs differ and the remaining bits are equal.
- **`count`:** a registered counter, updated each cycle as follows.
  - Push only: +1.
  - Pop only: −1.
  - Both or neither: unchanged.
- **Push when full, no pop in the same cycle:**
  - The sample is dropped.
  - Pointers and `count` are unchanged.
  - `ovf` is set.
- **Push when full with a pop in the same cycle:** the push is accepted and `count` stays at `DEPTH`.
- **Push and pop when empty:** no bypass. The sample is stored and appears on `m_valid` in the next cycle. Because `m_valid` is low while empty, no pop can occur in that cycle.
- **`ovf`:** stays set until `ovf_clr` is sampled high.
  - If `ovf_clr` and a new overflow occur in the same cycle, `ovf` remains 1; set wins.
- **`m_data`:** comes from storage indexed by `rd_ptr`.
  - When `m_valid` is low, its value is don't-care.
  - It must hold stable while `m_valid && !m_ready`.
- **Storage:** not reset. Only the control state is reset.

## Timing
- **Reset values** (asynchronous on `rst` high, released synchronously by design convention):
  - `m_valid` = 0, `count` = 0, `afull` = 0, `ovf` = 0.
  - `wr_ptr` and `rd_ptr` = 0.
  - `m_data` = X/don't-care.
- **Latency:** `y_dv` high in cycle N gives `m_valid` high in cycle N+1 when the FIFO was empty.
- **Throughput:** one push and one pop per cycle, sustained.
- **Registered outputs:** `count`, `afull` and `ovf` update at the clock edge following the causing event.
  - `m_valid` is the registered not-empty state.
- **Reset mid-operation:** all contents are discarded immediately and `m_valid` drops asynchronously. Any `y_dv` pulses during reset are ignored.
- **Handshake rules for the consumer:**
  - Once `m_valid` is asserted, it is never deasserted without a pop.
  - `m_valid` must not depend combinationally on `m_ready`.

## Configuration
- **`QUADRA_OBUF_STATS_EN` defined:** adds two outputs.
  - `stat_in`, 32 bits: counts every `y_dv` cycle.
  - `stat_drop`, 16 bits: counts dropped samples.
  - Both reset to 0 and saturate at all-ones with no wrap.
  - `ovf_clr` does not clear them.
- **`QUADRA_OBUF_STATS_EN` undefined:** the two ports and their counters do not exist. All other behaviour is identical.

## Test plan
- **Reset check:** hold `rst`=1 for 3 cycles, then release → `m_valid`=0, `count`=0, `afull`=0, `ovf`=0.
- **Single sample:** push `y`=0x123 in cycle 5 with `m_ready`=1 → `m_valid`=1 and `m_data`=0x123 in cycle 6; `count` returns to 0 in cycle 7.
- **Fill and overflow:** `m_ready`=0, push 10 consecutive samples 1..10 with `DEPTH`=8.
  - `count`=8; `afull` asserts after the 6th push.
  - `ovf`=1; samples 9 and 10 are lost.
  - Draining yields 1..8 in order.
  - With stats enabled: `stat_in`=10, `stat_drop`=2.
- **Full with simultaneous traffic:** fill to 8, then push 0xAA while popping → `count` stays 8, `ovf` stays 0, and 0xAA is the last sample drained.
- **`ovf_clr` priority:** with `ovf`=1, assert `ovf_clr` together with an overflowing push → `ovf`=1. Then assert `ovf_clr` alone → `ovf`=0.
- **Reset mid-operation:** assert `rst` with `count`=5 and `m_valid`=1 → `m_valid`=0 and `count`=0 without waiting for a clock edge. After release, the next push of 0x55 is the first sample out.

Source files
------------

// File: rtl/quadra_obuf.sv
// First-word-fall-through output buffer behind the quadra pipeline: absorbs consumer stalls, flags drops.
// Optional build macro QUADRA_OBUF_STATS_EN adds saturating input/drop statistics counters.
module quadra_obuf #(
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6,
    parameter int WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           y,
    input  logic                       y_dv,
    output logic [WIDTH-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       afull,
    output logic                       ovf,
    input  logic                       ovf_clr
`ifdef QUADRA_OBUF_STATS_EN
    ,
    output logic [31:0]                stat_in,
    output logic [15:0]                stat_drop
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    count_r;
    logic             valid_r;
    logic             afull_r;
    logic             ovf_r;

    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [PW-1:0]    count_nxt_s;
    logic             ovf_nxt_s;
    logic             full_s;
    logic             pop_s;
    logic             push_ok_s;
    logic             drop_s;

    // Handshake decode; a full buffer still takes a push when the head leaves in the same cycle
    always_comb begin
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s     = valid_r && m_ready;
        push_ok_s = y_dv && (!full_s || pop_s);
        drop_s    = y_dv && full_s && !pop_s;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag (set beats clear)
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = ovf_r;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_ok_s && !pop_s) begin
            count_nxt_s = count_r + PW'(1);
        end else if (pop_s && !push_ok_s) begin
            count_nxt_s = count_r - PW'(1);
        end else begin
            count_nxt_s = count_r;
        end
        if (drop_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Control state register; flags are registered from next-state so they track count exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {PW{1'b0}};
            valid_r  <= 1'b0;
            afull_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != {PW{1'b0}});
            afull_r  <= (count_nxt_s >= PW'(AFULL_LVL));
            ovf_r    <= ovf_nxt_s;
        end
    end

    // Sample storage, deliberately without reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= y;
        end
    end

    assign m_data  = mem_r[rd_ptr_r[AW-1:0]];
    assign m_valid = valid_r;
    assign count   = count_r;
    assign afull   = afull_r;
    assign ovf     = ovf_r;

`ifdef QUADRA_OBUF_STATS_EN
    logic [31:0] stat_in_r;
    logic [15:0] stat_drop_r;

    // Saturating statistics; untouched by ovf_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_in_r   <= 32'd0;
            stat_drop_r <= 16'd0;
        end else begin
            if (y_dv && (stat_in_r != {32{1'b1}})) begin
                stat_in_r <= stat_in_r + 32'd1;
            end
            if (drop_s && (stat_drop_r != {16{1'b1}})) begin
                stat_drop_r <= stat_drop_r + 16'd1;
            end
        end
    end

    assign stat_in   = stat_in_r;
    assign stat_drop = stat_drop_r;
`endif

endmodule
